// File: rtl/output_vc_allocator.sv
// output_vc_allocator
//   Per-output-port virtual-channel allocator. Each cycle it picks at most
//   one eligible head-flit requester (round-robin across requesters) and
//   hands it one free output VC from that requester's class mask. In the
//   same cycle it pulses the availability-reset line of the chosen VC
//   controller. The grant itself is registered and shows up one cycle later.
//
//   Optional feature macro: VA_RR_VC_SELECT_EN
//     defined   - VC choice rotates through the candidate VCs (vc_ptr)
//     undefined - the lowest-index candidate VC wins
//
// Ports
//   clk              : clock, rising edge
//   rstn             : synchronous active-low reset
//   req              : [NUM_REQ] head-flit requests, held until granted
//   req_vc_mask      : [NUM_REQ*4] allowed output VCs per requester
//   out_vc_avail     : [4] availability flags from the output VC controllers
//   out_vc_avail_rst : [4] one-hot availability reset, combinational
//   gnt              : [NUM_REQ] registered one-hot grant pulse
//   gnt_vcid         : [2] registered VCID of the last grant
//   gnt_valid        : registered, equals |gnt
module output_vc_allocator #(
  parameter int NUM_REQ = 5,
  parameter int NUM_VC  = 4
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*NUM_VC-1:0] req_vc_mask,
  input  logic [NUM_VC-1:0]         out_vc_avail,
  output logic [NUM_VC-1:0]         out_vc_avail_rst,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [1:0]                gnt_vcid,
  output logic                      gnt_valid
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  if (NUM_VC != 4) begin : g_bad_num_vc
    $error("output_vc_allocator: NUM_VC must be 4");
  end
  if (NUM_REQ < 2 || NUM_REQ > 32) begin : g_bad_num_req
    $error("output_vc_allocator: NUM_REQ must be 2..32");
  end

  logic [PW-1:0]      rr_ptr;
  logic [NUM_VC-1:0]  last_rst;
  logic [NUM_VC-1:0]  avail_eff;
  logic [NUM_REQ-1:0] elig;
  logic               found;
  logic [PW-1:0]      win;
  logic [NUM_VC-1:0]  cand;
  logic [1:0]         vc_sel;
  logic [NUM_REQ-1:0] gnt_nxt;

  // A VC pulsed last cycle may still show its flag high; keep it out for a cycle.
  assign avail_eff = out_vc_avail & ~last_rst;

  // gnt masks a requester that is still holding req in the cycle after its grant.
  always_comb begin
    elig = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      elig[i] = req[i] & ~gnt[i] & (|(req_vc_mask[i*NUM_VC +: NUM_VC] & avail_eff));
    end
  end

  // Round-robin search starting at rr_ptr, wrapping at NUM_REQ.
  always_comb begin
    int idx;
    found = 1'b0;
    win   = '0;
    idx   = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found && elig[idx]) begin
        found = 1'b1;
        win   = PW'(idx);
      end
    end
  end

  assign cand = req_vc_mask[int'(win)*NUM_VC +: NUM_VC] & avail_eff;

`ifdef VA_RR_VC_SELECT_EN
  logic [1:0] vc_ptr;

  always_comb begin
    logic [1:0] v;
    logic       hit;
    vc_sel = vc_ptr;
    hit    = 1'b0;
    v      = vc_ptr;
    for (int k = 0; k < 4; k++) begin
      v = vc_ptr + 2'(k);
      if (!hit && cand[v]) begin
        hit    = 1'b1;
        vc_sel = v;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      vc_ptr <= 2'd0;
    end else if (found) begin
      vc_ptr <= vc_sel + 2'd1;
    end
  end
`else
  always_comb begin
    vc_sel = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      if (cand[k]) vc_sel = 2'(k);
    end
  end
`endif

  always_comb begin
    out_vc_avail_rst = '0;
    if (rstn && found) out_vc_avail_rst[vc_sel] = 1'b1;
  end

  always_comb begin
    gnt_nxt = '0;
    if (found) gnt_nxt[win] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      gnt       <= '0;
      gnt_valid <= 1'b0;
      gnt_vcid  <= 2'd0;
      rr_ptr    <= '0;
      last_rst  <= '0;
    end else begin
      last_rst  <= out_vc_avail_rst;
      gnt       <= gnt_nxt;
      gnt_valid <= found;
      if (found) begin
        gnt_vcid <= vc_sel;
        rr_ptr   <= (win == PW'(NUM_REQ - 1)) ? '0 : win + 1'b1;
      end
    end
  end

endmodule
